// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states,
// decoder load/store type codes and the alignment rule.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Load types as driven by the decoder's lw_imm_sel; 101-111 act as lw.
   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_B  = 3'b010;
   localparam logic [2:0] LD_HU = 3'b011;
   localparam logic [2:0] LD_BU = 3'b100;

   // Store types as driven by the decoder's sw_imm_sel; 11 acts as sw.
   localparam logic [1:0] ST_W = 2'b00;
   localparam logic [1:0] ST_B = 2'b01;
   localparam logic [1:0] ST_H = 2'b10;

   // Natural alignment check: words on 4-byte, halves on 2-byte boundaries.
   function automatic logic access_aligned(input logic       is_store,
                                           input logic [2:0] ld_type,
                                           input logic [1:0] st_type,
                                           input logic [1:0] off);
      logic ok;
      if (is_store) begin
         case (st_type)
            ST_B:    ok = 1'b1;
            ST_H:    ok = (off[0] == 1'b0);
            default: ok = (off == 2'b00);
         endcase
      end else begin
         case (ld_type)
            LD_B, LD_BU: ok = 1'b1;
            LD_H, LD_HU: ok = (off[0] == 1'b0);
            default:     ok = (off == 2'b00);
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
//
// Handshake: the master raises mem_req together with mem_we, mem_addr,
// mem_wdata and mem_be, and holds all of them stable until the slave
// answers with a one-cycle mem_ack. mem_rdata is only meaningful in the
// cycle mem_ack is high. The master drops mem_req in the cycle after the
// ack; an ack seen while mem_req is low is ignored.
interface load_store_unit_if #(
   parameter int XLEN = 32
) ();

   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [3:0]      mem_be;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane-replicated store data,
// plus byte/half extraction with sign or zero extension for loads.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      ld_type,
   input  logic [1:0]      st_type,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_lane,
   output logic [XLEN-1:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store side: replicate the datum into every lane, enable only the target lanes.
   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      case (st_type)
         ST_B: begin
            be         = 4'b0001 << offset;
            wdata_lane = {(XLEN/8){wdata[7:0]}};
         end
         ST_H: begin
            be         = offset[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {(XLEN/16){wdata[15:0]}};
         end
         default: begin
            be         = 4'b1111;
            wdata_lane = wdata;
         end
      endcase
   end

   // Load side: pick the addressed byte/half and extend it to XLEN.
   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
      case (ld_type)
         LD_B:    rdata_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LD_BU:   rdata_ext = {{(XLEN-8){1'b0}}, byte_sel};
         LD_H:    rdata_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
         LD_HU:   rdata_ext = {{(XLEN-16){1'b0}}, half_sel};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns the decoder's load/store request into one
// req/ack transaction on the data-memory bus, stalling the single-cycle
// datapath until it completes (or times out).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld_req,
   input  logic                st_req,
   input  logic [2:0]          lw_imm_sel,
   input  logic [1:0]          sw_imm_sel,
   input  logic [XLEN-1:0]     addr,
   input  logic [XLEN-1:0]     wdata,
   output logic [XLEN-1:0]     rdata_out,
   output logic                stall,
   output logic                misalign,
   output logic                bus_err,
   load_store_unit_if.master   mem,
   output lsu_state_t          state_dbg
);

   localparam bit TMO_EN = (TIMEOUT != 0);
   localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TMO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] TMO_LAST = TMO_M1[CW-1:0];

   lsu_state_t      state;
   logic [2:0]      ld_type_q;
   logic [1:0]      off_q;
   logic [CW-1:0]   tmo_cnt;

   logic            st_go;
   logic            ld_go;
   logic            aligned;
   logic            req_ok;
   logic            tmo_hit;
   logic [1:0]      align_off;
   logic [3:0]      be_lane;
   logic [XLEN-1:0] wdata_lane;
   logic [XLEN-1:0] rdata_ext;

   assign state_dbg = state;

   // Request decode: stores win over loads; stall as soon as a legal access is seen.
   always_comb begin
      st_go    = st_req;
      ld_go    = ld_req && !st_req;
      aligned  = access_aligned(st_go, lw_imm_sel, sw_imm_sel, addr[1:0]);
      req_ok   = (state == IDLE) && (st_go || ld_go) && aligned;
      misalign = (state == IDLE) && (st_go || ld_go) && !aligned;
      stall    = req_ok || (state == REQ);
      tmo_hit  = TMO_EN && (tmo_cnt == TMO_LAST);
      // Store lanes come from the live address; load extraction from the latched one.
      align_off = (state == IDLE) ? addr[1:0] : off_q;
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .ld_type    (ld_type_q),
      .st_type    (sw_imm_sel),
      .offset     (align_off),
      .wdata      (wdata),
      .rdata      (mem.mem_rdata),
      .be         (be_lane),
      .wdata_lane (wdata_lane),
      .rdata_ext  (rdata_ext)
   );

   // Transaction FSM with registered bus outputs, result and timeout counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         mem.mem_be    <= 4'b0000;
         rdata_out     <= '0;
         bus_err       <= 1'b0;
         tmo_cnt       <= '0;
         ld_type_q     <= LD_W;
         off_q         <= 2'b00;
      end else begin
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (req_ok) begin
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= st_go;
                  mem.mem_addr  <= {addr[XLEN-1:2], 2'b00};
                  mem.mem_be    <= st_go ? be_lane : 4'b1111;
                  mem.mem_wdata <= st_go ? wdata_lane : '0;
                  ld_type_q     <= lw_imm_sel;
                  off_q         <= addr[1:0];
                  tmo_cnt       <= '0;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (mem.mem_ack) begin
                  if (!mem.mem_we) begin
                     rdata_out <= rdata_ext;
                  end
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= DONE;
               end else if (tmo_hit) begin
                  rdata_out   <= '0;
                  bus_err     <= 1'b1;
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            DONE: begin
               // The instruction that caused this access is still on the
               // decoder outputs, so any request seen here is not new.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
